// File: rtl/palette_pkg.sv
// Shared widths, FIFO entry layout and the channel fade helper for the palette reader.
// The fade helper is only referenced when PALETTE_FADE_EN is defined.
package palette_pkg;

    localparam int PAL_IDX_W  = 5;
    localparam int PAL_DATA_W = 16;
    localparam int RGB_W      = 12;
    localparam int CH_W       = 4;
    localparam int FADE_W     = 4;

    typedef struct packed {
        logic             last;
        logic [RGB_W-1:0] rgb;
    } pix_entry_t;

    // (c * (lvl + 1)) >> 4; the product never exceeds 15*16, so 8 bits suffice.
    function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] c,
                                                input logic [FADE_W-1:0] lvl);
        return CH_W'(({4'b0000, c} * ({4'b0000, lvl} + 8'd1)) >> 4);
    endfunction

    function automatic logic [RGB_W-1:0] fade_rgb(input logic [RGB_W-1:0] rgb,
                                                  input logic [FADE_W-1:0] lvl);
        return {fade_ch(rgb[11:8], lvl), fade_ch(rgb[7:4], lvl), fade_ch(rgb[3:0], lvl)};
    endfunction

endpackage

// File: rtl/palette_rd_fifo.sv
// Small register-based FIFO holding looked-up colours; pointers wrap modulo DEPTH,
// so DEPTH need not be a power of two. Push and pop together are legal even when full.
module palette_rd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        // When full, the slot being written is the one being popped this same edge.
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/palette_reader.sv
// Pixel index -> palette RAM lookup -> colour FIFO, one pixel per clock.
// Optional PALETTE_FADE_EN adds a fade_i port that scales each channel at FIFO write.
module palette_reader
    import palette_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    input  logic [PAL_IDX_W-1:0]  pix_idx_i,
    input  logic                  pix_last_i,
    output logic [PAL_IDX_W-1:0]  pal_rd_addr_o,
    output logic                  pal_rd_en_o,
    input  logic [PAL_DATA_W-1:0] pal_rd_data_i,
    output logic                  rgb_valid_o,
    input  logic                  rgb_ready_i,
    output logic [RGB_W-1:0]      rgb_o,
    output logic                  rgb_last_o
`ifdef PALETTE_FADE_EN
   ,input  logic [FADE_W-1:0]     fade_i
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;
    logic             accept;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic [RGB_W-1:0] colour;
    pix_entry_t       push_entry;
    pix_entry_t       head_entry;
    logic             pop;

    logic [PAL_DATA_W-RGB_W-1:0] unused_pal_hi;
    assign unused_pal_hi = pal_rd_data_i[PAL_DATA_W-1:RGB_W];

    // Count the in-flight read as occupied so its RAM data always has a slot.
    // Ready depends only on flops (and reset), never on rgb_ready_i.
    assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign pix_ready_o = !rst_i && (occupancy < (CNT_W + 1)'(DEPTH));
    assign accept      = pix_valid_i && pix_ready_o;

    assign pal_rd_addr_o = pix_idx_i;
    assign pal_rd_en_o   = accept;

    always_comb begin
        inflight_d      = accept;
        inflight_last_d = accept && pix_last_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

`ifdef PALETTE_FADE_EN
    assign colour = fade_rgb(pal_rd_data_i[RGB_W-1:0], fade_i);
`else
    assign colour = pal_rd_data_i[RGB_W-1:0];
`endif

    assign push_entry = '{last: inflight_last_q, rgb: colour};
    assign pop        = rgb_valid_o && rgb_ready_i;

    logic [RGB_W:0] head_raw;

    palette_rd_fifo #(
        .WIDTH (RGB_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight_q),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_raw),
        .count_o (fifo_count)
    );

    assign head_entry  = head_raw;
    assign rgb_valid_o = (fifo_count != '0);
    assign rgb_o       = rgb_valid_o ? head_entry.rgb  : '0;
    assign rgb_last_o  = rgb_valid_o ? head_entry.last : 1'b0;

endmodule
